// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding, byte count and counter width for the AES core arbiter
package aes_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;
  localparam int NBYTES = 16;
  localparam int TMO_W = 8;
  function automatic logic [7:0] byte_at(input logic [127:0] v, input logic [3:0] n);
    return v[{~n, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/aes_core_arbiter_if.sv
// aes_core_arbiter_if: requester job bus and response bus of the AES core arbiter
interface aes_core_arbiter_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_key;
  logic [255:0] req_text;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_data;
  logic         rsp_err;
  modport master (
    output req_valid, req_key, req_text, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport slave (
    input  req_valid, req_key, req_text, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/aes_rr_arb2.sv
// aes_rr_arb2: two-way round-robin picker favouring the requester not served last
module aes_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  logic ptr_q, ptr_d;
  assign gnt_id = &req ? ptr_q : req[1];
  assign gnt = (en && |req) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  // preference moves to the other requester whenever a grant is issued
  always_comb ptr_d = |gnt ? ~gnt_id : ptr_q;
  // requester 0 is preferred out of reset
  always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one byte-serial AES core between two requesters
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  aes_core_arbiter_if.slave bus,
  output logic             core_enable,
  output logic [7:0]       core_key_byte,
  output logic [7:0]       core_state_byte,
  input  logic             core_ready,
  input  logic [7:0]       core_out_byte
);
  localparam logic [TMO_W-1:0] LAST_BYTE = TMO_W'(NBYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  state_t             state_q, state_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       key_q, key_d, text_q, text_d, rsp_data_q, rsp_data_d;
  logic               rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic               rsp_valid_q, rsp_valid_d, core_enable_q, core_enable_d;
  logic [7:0]         key_byte_q, key_byte_d, state_byte_q, state_byte_d;
  logic [1:0]         gnt;
  logic               gnt_id, feeding;

  aes_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == S_IDLE && !rst),
    .req    (bus.req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.req_ready    = gnt;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign core_enable      = core_enable_q;
  assign core_key_byte    = key_byte_q;
  assign core_state_byte  = state_byte_q;

  // job sequencing; every output is computed from the next state so it is registered
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    text_d     = text_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: if (|gnt) begin
        state_d    = S_START;
        key_d      = gnt_id ? bus.req_key[255:128] : bus.req_key[127:0];
        text_d     = gnt_id ? bus.req_text[255:128] : bus.req_text[127:0];
        rsp_id_d   = gnt_id;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
      end
      S_START: state_d = S_FEED;
      S_FEED:  state_d = (cnt_q == LAST_BYTE) ? S_WAIT : S_FEED;
      S_WAIT: begin
        if (core_ready) state_d = S_DRAIN;
        else if (cnt_q == TMO_LIM) begin
          state_d    = S_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end
      end
      S_DRAIN: begin
        if (!core_ready) begin
          state_d    = S_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          rsp_data_d = {rsp_data_q[119:0], core_out_byte};
          state_d    = (cnt_q == LAST_BYTE) ? S_RESP : S_DRAIN;
        end
      end
      S_RESP:  state_d = bus.rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
    cnt_d         = (state_d == state_q && state_q inside {S_FEED, S_WAIT, S_DRAIN}) ? cnt_q + 1'b1 : '0;
    feeding       = state_d == S_START || state_d == S_FEED;
    core_enable_d = state_d inside {S_START, S_FEED, S_WAIT, S_DRAIN};
    rsp_valid_d   = state_d == S_RESP;
    key_byte_d    = feeding ? byte_at(key_d, cnt_d[3:0]) : 8'h00;
    state_byte_d  = feeding ? byte_at(text_d, cnt_d[3:0]) : 8'h00;
  end

  // state and output registers; reset abandons any job in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      key_q         <= '0;
      text_q        <= '0;
      rsp_id_q      <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      core_enable_q <= 1'b0;
      key_byte_q    <= '0;
      state_byte_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_q         <= key_d;
      text_q        <= text_d;
      rsp_id_q      <= rsp_id_d;
      rsp_err_q     <= rsp_err_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      core_enable_q <= core_enable_d;
      key_byte_q    <= key_byte_d;
      state_byte_q  <= state_byte_d;
    end
  end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed-vector bench with a hand-driven byte-serial core stub
module tb_aes_core_arbiter;
  logic       clk, rst, core_enable, core_ready;
  logic [7:0] core_key_byte, core_state_byte, core_out_byte;
  int         cyc, n_chk, n_fail;
  logic [127:0] key_a [2];
  logic [127:0] text_a [2];
  logic [127:0] ct_a [2];

  aes_core_arbiter_if bus ();

  aes_core_arbiter #(.TIMEOUT(20)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .core_enable     (core_enable),
    .core_key_byte   (core_key_byte),
    .core_state_byte (core_state_byte),
    .core_ready      (core_ready),
    .core_out_byte   (core_out_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int n);
    logic [127:0] t;
    t = v >> (8 * (15 - n));
    return t[7:0];
  endfunction

  task automatic chk_reset;
    check("rst_req_ready", 128'(bus.req_ready), 128'(2'b00));
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
    check("rst_rsp_id", 128'(bus.rsp_id), 128'(1'b0));
    check("rst_rsp_data", bus.rsp_data, 128'h0);
    check("rst_rsp_err", 128'(bus.rsp_err), 128'(1'b0));
    check("rst_core_en", 128'(core_enable), 128'(1'b0));
    check("rst_key_byte", 128'(core_key_byte), 128'(8'h00));
    check("rst_state_byte", 128'(core_state_byte), 128'(8'h00));
  endtask

  // w = WAIT cycles until core_ready (negative: never); drop = DRAIN byte where core_ready falls
  task automatic run_job(input logic [1:0] v, input logic [1:0] v_after, input int rid,
                         input int w, input int drop, input int hold);
    logic [127:0] gk, gt, exp_data;
    logic exp_err, ok, rid_b;
    int g, lat;
    rid_b    = rid[0];
    exp_err  = (w < 0) || (drop >= 0);
    exp_data = exp_err ? 128'h0 : ct_a[rid];
    bus.rsp_ready = (hold == 0);
    bus.req_valid = v;
    #1;
    check("grant", 128'(bus.req_ready), 128'(rid_b ? 2'b10 : 2'b01));
    g = cyc;
    step;
    bus.req_valid = v_after;
    #1;
    check("busy_no_grant", 128'(bus.req_ready), 128'(2'b00));
    check("start_en", 128'(core_enable), 128'(1'b1));
    check("start_byte", 128'(core_key_byte), 128'(byte_of(key_a[rid], 0)));
    gk = '0;
    gt = '0;
    for (int n = 0; n < 16; n++) begin
      step;
      gk = {gk[119:0], core_key_byte};
      gt = {gt[119:0], core_state_byte};
    end
    check("feed_key", gk, key_a[rid]);
    check("feed_text", gt, text_a[rid]);
    ok = 1'b1;
    if (w < 0) begin
      core_ready = 1'b0;
      step;
      lat = 0;
      while (!bus.rsp_valid && lat < 100) begin
        ok = ok & core_enable;
        step;
        lat++;
      end
      check("tmo_latency", 128'(lat), 128'(21));
    end else begin
      for (int i = 0; i < w; i++) begin
        step;
        ok = ok & core_enable;
        core_ready = (i == w - 1);
        core_out_byte = 8'hee;
      end
      for (int j = 0; j < 16; j++) begin
        step;
        ok = ok & core_enable;
        core_ready = (j != drop);
        core_out_byte = byte_of(ct_a[rid], j);
        if (j == drop) break;
      end
      step;
      if (drop < 0) check("latency", 128'(cyc - g), 128'(34 + w));
    end
    core_ready = 1'b0;
    check("busy_en", 128'(ok), 128'(1'b1));
    check("rsp_valid", 128'(bus.rsp_valid), 128'(1'b1));
    check("rsp_id", 128'(bus.rsp_id), 128'(rid_b));
    check("rsp_err", 128'(bus.rsp_err), 128'(exp_err));
    check("rsp_data", bus.rsp_data, exp_data);
    check("resp_en", 128'(core_enable), 128'(1'b0));
    if (hold > 0) begin
      ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
        step;
        ok = ok && bus.rsp_valid && bus.rsp_data == exp_data && bus.rsp_id == rid_b &&
             bus.rsp_err == exp_err && bus.req_ready == 2'b00 && !core_enable;
      end
      check("hold_stable", 128'(ok), 128'(1'b1));
      bus.rsp_ready = 1'b1;
    end
    step;
    check("idle_valid", 128'(bus.rsp_valid), 128'(1'b0));
    check("idle_en", 128'(core_enable), 128'(1'b0));
  endtask

  initial begin
    cyc = 0;
    n_chk = 0;
    n_fail = 0;
    key_a[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    text_a[0] = 128'h00112233445566778899aabbccddeeff;
    ct_a[0]   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    key_a[1]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    text_a[1] = 128'h3243f6a8885a308d313198a2e0370734;
    ct_a[1]   = 128'h3925841d02dc09fbdc118597196a0b32;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_key   = {key_a[1], key_a[0]};
    bus.req_text  = {text_a[1], text_a[0]};
    bus.rsp_ready = 1'b0;
    core_ready    = 1'b0;
    core_out_byte = 8'h00;
    step;
    step;
    chk_reset();
    rst = 1'b0;
    run_job(2'b11, 2'b11, 0, 3, -1, 0);
    run_job(2'b11, 2'b11, 1, 1, -1, 0);
    run_job(2'b11, 2'b11, 0, 5, -1, 0);
    run_job(2'b11, 2'b11, 1, 2, -1, 0);
    run_job(2'b11, 2'b11, 0, 2, -1, 10);
    run_job(2'b10, 2'b00, 1, 21, -1, 0);
    run_job(2'b01, 2'b00, 0, -1, -1, 0);
    run_job(2'b10, 2'b00, 1, 4, 5, 0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    #1;
    check("mr_grant", 128'(bus.req_ready), 128'(2'b01));
    step;
    bus.req_valid = 2'b00;
    for (int n = 0; n < 8; n++) step;
    check("mr_feed7", 128'(core_key_byte), 128'(byte_of(key_a[0], 7)));
    rst = 1'b1;
    bus.req_valid = 2'b11;
    step;
    chk_reset();
    rst = 1'b0;
    run_job(2'b11, 2'b00, 0, 2, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles in WAIT for core_ready before abort (1..255).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high; also drives the AES core's rst.
REQ-004 req_valid  input  2  per-requester job request; bit i = requester i.
REQ-005 req_ready  output  2  one-cycle grant/accept pulse per requester.
REQ-006 req_key  input  256  128-bit keys, requester i at [128*i +: 128].
REQ-007 req_text  input  256  128-bit plaintexts, same packing.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester owning the result.
REQ-011 rsp_data  output  128  ciphertext, byte 0 in bits [127:120].
REQ-012 rsp_err  output  1  job aborted by timeout.
REQ-013 core_enable  output  1  AES core enable, registered.
REQ-014 core_key_byte  output  8  key byte to core.
REQ-015 core_state_byte  output  8  plaintext byte to core.
REQ-016 core_ready  input  1  core output-phase flag.
REQ-017 core_out_byte  input  8  core ciphertext byte.

Function
REQ-018 States: IDLE, START, FEED, WAIT, DRAIN, RESP; one-hot or binary encoding allowed.
REQ-019 IDLE: core_enable=0; if any req_valid, grant round-robin (requester other than last served wins ties; requester 0 preferred after reset), pulse req_ready[g] this cycle, capture key/text/id, go START.
REQ-020 No grant in any state other than IDLE; req_ready is never high for both bits.
REQ-021 START: one cycle, core_enable=1, core bytes = byte 0; go FEED with byte counter 0.
REQ-022 FEED: 16 cycles, core_enable=1, drive byte n (MSB first) of key and text on cycle n; after n=15 go WAIT.
REQ-023 WAIT: core_enable=1, 8-bit counter from 0; on core_ready=1 go DRAIN (that cycle's core_out_byte ignored); if counter reaches TIMEOUT first, go RESP with rsp_err=1, rsp_data=0.
REQ-024 DRAIN: 16 cycles, capture core_out_byte each cycle into rsp_data byte n, MSB first; after byte 15 drop core_enable and go RESP with rsp_err=0.
REQ-025 core_ready dropping during DRAIN is a protocol error: go RESP with rsp_err=1, rsp_data=0.
REQ-026 RESP: core_enable=0, rsp_valid=1, rsp_id/data/err stable; on rsp_ready=1 go IDLE next cycle; core_enable is therefore low at least one cycle between jobs.
REQ-027 Nominal latency grant-to-rsp_valid = 1+16+W+16+1 cycles, W = WAIT cycles.
REQ-028 req_valid dropping after grant has no effect; captured job completes.
REQ-029 rsp_valid and rsp_ready high on entry to RESP: accepted that cycle, IDLE next cycle.

Reset
REQ-030 On rst: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, core_enable=0, core bytes=0, counters=0, round-robin pointer=requester 0.
REQ-031 rst mid-job abandons the job with no response; no grant in the rst cycle.

Structure
REQ-032 State encoding, byte count 16 and timeout counter width in shared package aes_pkg.
REQ-033 Single sub-module: aes_rr_arb2 (2-way round-robin picker with pointer update on grant).
REQ-034 The AES core is instantiated by the parent, not by this block.

Verification
REQ-035 Req0 key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff with core -> rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
REQ-036 Both req_valid high continuously for 4 jobs -> grants 0,1,0,1; each rsp_id matches.
REQ-037 Core stub never raises core_ready, TIMEOUT=20 -> rsp_valid exactly 21 cycles after WAIT entry, rsp_err=1, rsp_data=0.
REQ-038 rsp_ready held low 10 cycles -> rsp_* stable, no req_ready, core_enable=0 throughout.
REQ-039 rst asserted on FEED byte 7 -> next cycle all REQ-030 values; next job completes correctly.
REQ-040 Stub drops core_ready on DRAIN byte 5 -> rsp_err=1, rsp_data=0.
